// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master round-robin arbiter for one native minrv32
// memory port. A grant is held from arbitration until the granted transaction
// completes or the granted master abandons it. The payload mux and the
// ready/rdata return path are combinational.
//
// Optional feature macro: MEM_BUS_ARB_TIMEOUT_EN. When it is defined, a wait
// counter ends a stalled transaction after TIMEOUT_CYCLES slave wait cycles.
// That forced completion pulses ready and err to the granted master.
module mem_bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 31
) (
   input  logic        clk,
   input  logic        resetn,
   // master 0
   input  logic        m0_valid,
   input  logic        m0_instr,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   // master 1
   input  logic        m1_valid,
   input  logic        m1_instr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   // shared slave port
   output logic        s_valid,
   output logic        s_instr,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,
   // status
   output logic        grant,
   output logic        busy
);

   // The watchdog counter is 8 bits wide, so its limit must lie in 1..255.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("mem_bus_arbiter: TIMEOUT_CYCLES must lie in 1..255");
   end

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic        grant_q, grant_d;
   logic        last_q, last_d;
   logic        winner;
   logic        in_busy;
   logic        sel_valid;
   logic        sel_ready;
   logic        sel_err;
   logic [31:0] sel_rdata;
   logic        timeout_hit;

   assign in_busy   = (state_q == BUSY);
   assign sel_valid = grant_q ? m1_valid : m0_valid;

`ifdef MEM_BUS_ARB_TIMEOUT_EN
   localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] wcnt_q, wcnt_d;

   // Count slave wait cycles. The count is held at zero while IDLE, so each
   // new grant starts its count from zero.
   always_comb begin
      wcnt_d = wcnt_q;
      if (!in_busy) begin
         wcnt_d = '0;
      end else if (sel_valid && !s_ready) begin
         wcnt_d = wcnt_q + 8'd1;
      end
   end

   // Watchdog counter register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wcnt_q <= '0;
      end else begin
         wcnt_q <= wcnt_d;
      end
   end

   // A real s_ready in the last allowed wait cycle wins over the watchdog.
   assign timeout_hit = in_busy && sel_valid && !s_ready && (wcnt_q == WCNT_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   // Payload follows the grant register at all times. It is qualified only by
   // s_valid.
   always_comb begin
      s_instr = grant_q ? m1_instr : m0_instr;
      s_addr  = grant_q ? m1_addr  : m0_addr;
      s_wdata = grant_q ? m1_wdata : m0_wdata;
      s_wstrb = grant_q ? m1_wstrb : m0_wstrb;
   end

   // Return path: completion, error and read data are steered to the granted master only.
   always_comb begin
      s_valid   = in_busy && sel_valid && !timeout_hit;
      sel_ready = in_busy && sel_valid && (s_ready || timeout_hit);
      sel_err   = timeout_hit;
      sel_rdata = (in_busy && !timeout_hit) ? s_rdata : 32'h0;
      m0_ready  = sel_ready && !grant_q;
      m1_ready  = sel_ready &&  grant_q;
      m0_err    = sel_err   && !grant_q;
      m1_err    = sel_err   &&  grant_q;
      m0_rdata  = grant_q ? 32'h0 : sel_rdata;
      m1_rdata  = grant_q ? sel_rdata : 32'h0;
      grant     = grant_q;
      busy      = in_busy;
   end

   // Next-state logic: round-robin arbitration in IDLE, and hold the grant while BUSY.
   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves one unassigned and infers a latch.
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      winner  = grant_q;
      case (state_q)
         IDLE: begin
            if (m0_valid || m1_valid) begin
               // On a tie, the master that did not win the last grant goes next.
               winner  = (m0_valid && m1_valid) ? !last_q : m1_valid;
               grant_d = winner;
               last_d  = winner;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // Leave BUSY on completion, on abandon, or on a watchdog termination.
            if (!sel_valid || s_ready || timeout_hit) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      if (!resetn) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter that shares one native minrv32 memory port (valid/ready, addr, wdata, wstrb, rdata, instr) between two requesters, e.g. a core and a DMA/debug master, in front of a single memory or formal memory model. Round-robin arbitration; a grant is held until the granted transaction completes. Optional watchdog terminates stalled transactions with an error pulse.

## Interface
- `TIMEOUT_CYCLES`, 31: wait cycles (`s_valid && !s_ready`) before a forced termination; used only with `MEM_BUS_ARB_TIMEOUT_EN`; legal range 1..255.
- `clk`  in  1  clock, all state on rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `m0_valid`, `m1_valid`  in  1  master request; held with payload stable until that master's ready.
- `m0_instr`, `m1_instr`  in  1  instruction-fetch flag.
- `m0_addr`, `m1_addr`  in  32  byte address.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_wstrb`, `m1_wstrb`  in  4  byte strobes; 0 means read.
- `m0_ready`, `m1_ready`  out  1  completion to the granted master only.
- `m0_rdata`, `m1_rdata`  out  32  read data.
- `m0_err`, `m1_err`  out  1  one-cycle timeout-termination flag, coincident with ready.
- `s_valid`, `s_instr`, `s_addr`, `s_wdata`, `s_wstrb`  out  1/1/32/32/4  shared slave port.
- `s_ready`  in  1  slave completion.
- `s_rdata`  in  32  slave read data.
- `grant`  out  1  index of the current or last granted master.
- `busy`  out  1  high in BUSY.

## Operation
- States: IDLE, BUSY. Registers: `state`, `grant`, `last`, and `wcnt` when configured.
- IDLE: if exactly one master is valid, grant it. If both are valid, grant `!last`. Then `state<=BUSY` and `last<=` the winner. With no request, stay in IDLE.
- BUSY: slave payload is a combinational mux of the granted master's inputs. `s_valid = m<grant>_valid`.
  - `m<grant>_ready = s_ready`; the other ready is 0.
  - `m<grant>_rdata = s_rdata`; the ungranted rdata is 0.
- Completion is `s_valid && s_ready`. Then `state<=IDLE`; `grant` is held.
- Abandon: if the granted master drops valid in BUSY, the arbiter returns to IDLE with no ready issued.
- In IDLE, `s_valid` and all readys are 0. `s_addr`/`s_wdata`/`s_wstrb`/`s_instr` show the `grant` master's inputs; they are don't-care while `s_valid` is low.
- The ungranted master's request is never visible on the slave port and is never dropped: it waits.
- Reset values (after the clock edge with `resetn` low): `state`=IDLE, `grant`=0, `last`=1 (m0 wins the first tie), `wcnt`=0.
  - Resulting outputs: `s_valid`=0, `m0_ready`=`m1_ready`=0, `m0_err`=`m1_err`=0, `busy`=0.
- Reset mid-transaction: the transaction is dropped and no ready is issued. `s_valid` is low in the cycle after the reset edge.

## Timing
- Arbitration latency is 1 cycle: a request sampled in IDLE at edge N gives `s_valid` high during cycle N+1.
- Minimum transaction is 2 cycles (arbitrate, then a zero-wait ready). Back-to-back throughput is one transaction per 2 + waitstates cycles.
- Ready and rdata pass combinationally from `s_ready`/`s_rdata`; there is no registered return path.
- A new request from the same master in the cycle after its completion is arbitrated normally. If the other master is waiting, the other master wins.

## Configuration
- `MEM_BUS_ARB_TIMEOUT_EN` defined:
  - `wcnt` (8 bits) resets to 0 on entering BUSY and increments each cycle with `s_valid && !s_ready`.
  - In the cycle where `wcnt == TIMEOUT_CYCLES-1` and `s_ready` is still low, the arbiter forces `m<grant>_ready`=1, `m<grant>_err`=1, `m<grant>_rdata`=0 and `s_valid`=0 (combinationally), then `state<=IDLE`.
  - A real `s_ready` in that same cycle takes precedence: normal completion, no error.
- Undefined: no counter is built, BUSY waits indefinitely, and `m0_err`/`m1_err` are tied to 0.

## Test plan
- m0 read alone: `m0_valid` at edge 1, addr 0x100, wstrb 0; `s_ready`=1 with rdata 0xDEADBEEF in cycle 3.
  - Required: `s_valid` high in cycles 2–3, `s_addr`=0x100, `m0_ready` only in cycle 3 with `m0_rdata`=0xDEADBEEF, `m1_ready`=0 throughout.
- Tie after reset: both masters request continuously with zero-wait slave.
  - Required grant order m0, m1, m0, m1; each ready lands 2 cycles apart.
- m1 write: addr 0x200, wdata 0x11223344, wstrb 4'b0101, while m0 is idle.
  - Required: `s_wstrb`=0101, `s_wdata`=0x11223344, `s_instr`=`m1_instr`, `grant`=1.
- Reset mid-transaction: drive `resetn`=0 for one cycle during a 3-wait access.
  - Required: no ready to either master, `s_valid`=0 next cycle, next tie goes to m0.
- Timeout, with macro and `TIMEOUT_CYCLES`=4: m0 read, `s_ready` held 0.
  - Required: `m0_ready`=`m0_err`=1 and `m0_rdata`=0 in the 4th wait cycle, IDLE next cycle.
  - Without the macro: `s_valid` remains high for 100+ cycles and `m0_err` never asserts.
- Abandon: m1 drops valid after 1 wait cycle.
  - Required: return to IDLE, no `m1_ready`, pending m0 granted the following cycle.
